// File: rtl/encoder_value_bias_add_if.sv
// rtl/encoder_value_bias_add_if.sv - data_in/bias/data_out handshake bundle for encoder_value_bias_add
interface encoder_value_bias_add_if #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int DATA_OUT_PRECISION_0 = 17,
    parameter int PARALLELISM          = 1
) ();
    logic [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0]  data_in;
    logic                                             data_in_valid;
    logic                                             data_in_ready;
    logic [PARALLELISM-1:0][BIAS_PRECISION_0-1:0]     bias;
    logic                                             bias_valid;
    logic                                             bias_ready;
    logic [PARALLELISM-1:0][DATA_OUT_PRECISION_0-1:0] data_out;
    logic                                             data_out_valid;
    logic                                             data_out_ready;
    logic                                             data_out_last;

    modport master (
        output data_in, data_in_valid, bias, bias_valid, data_out_ready,
        input  data_in_ready, bias_ready, data_out, data_out_valid, data_out_last
    );

    modport slave (
        input  data_in, data_in_valid, bias, bias_valid, data_out_ready,
        output data_in_ready, bias_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/encoder_value_bias_add.sv
// rtl/encoder_value_bias_add.sv - joins data_in with bias, adds aligned bias per lane; ENCODER_VALUE_BIAS_ADD_SAT_EN selects clamping
module encoder_value_bias_add #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 8,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 17,
    parameter int PARALLELISM          = 1,
    parameter int TENSOR_SIZE_DIM_0    = 32
) (
    input logic                  clk,
    input logic                  rst,
    encoder_value_bias_add_if.slave bus
);
    localparam int DIN_W   = DATA_IN_PRECISION_0;
    localparam int BIAS_W  = BIAS_PRECISION_0;
    localparam int OUT_W   = DATA_OUT_PRECISION_0;
    localparam int SHIFT   = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
    localparam int SHIFT_U = (SHIFT < 0) ? 0 : SHIFT;
    localparam int ALIGN_W = BIAS_W + SHIFT_U;
    localparam int MAX_W   = (DIN_W > ALIGN_W) ? DIN_W : ALIGN_W;
    localparam int SUM_W   = MAX_W + 1;
    // One guard bit above both the full sum and the output width keeps every
    // sign extension below a non-zero replication.
    localparam int EXT_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int DEPTH   = TENSOR_SIZE_DIM_0 / PARALLELISM;
    localparam int CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // A bias with more fractional bits than data_in cannot be aligned by a left shift.
    if (SHIFT < 0) begin : g_bad_shift
        $error("BIAS_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
    end

    logic [OUT_W-1:0] lane_out [PARALLELISM];

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
        logic signed [EXT_W-1:0] din_ext;
        logic signed [EXT_W-1:0] bias_ext;
        logic signed [EXT_W-1:0] sum;

        assign din_ext  = {{(EXT_W-DIN_W){bus.data_in[i][DIN_W-1]}}, bus.data_in[i]};
        assign bias_ext = {{(EXT_W-BIAS_W){bus.bias[i][BIAS_W-1]}}, bus.bias[i]} <<< SHIFT_U;
        assign sum      = din_ext + bias_ext;

`ifdef ENCODER_VALUE_BIAS_ADD_SAT_EN
        localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
        assign lane_out[i] = (sum > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                             (sum < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sum[OUT_W-1:0];
`else
        // Two's complement wrap: the bits above the output width are dropped.
        logic unused_sum_hi;
        assign unused_sum_hi = ^sum[EXT_W-1:OUT_W];
        assign lane_out[i]   = sum[OUT_W-1:0];
`endif
    end

    logic [PARALLELISM-1:0][OUT_W-1:0] new_data;

    // Pack the per-lane results into one beat.
    always_comb begin
        new_data = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            new_data[i] = lane_out[i];
        end
    end

    logic [1:0]                        count;
    logic [PARALLELISM-1:0][OUT_W-1:0] head_data;
    logic [PARALLELISM-1:0][OUT_W-1:0] tail_data;
    logic                              head_last;
    logic                              tail_last;
    logic [CNT_W-1:0]                  beat_cnt;
    logic                              space;
    logic                              push;
    logic                              pop;
    logic                              new_last;

    // Space comes only from the held count, so input ready never sees data_out_ready.
    assign space    = (count != 2'd2);
    assign push     = bus.data_in_valid && bus.bias_valid && space && !rst;
    assign pop      = (count != 2'd0) && bus.data_out_ready;
    assign new_last = (beat_cnt == CNT_W'(DEPTH - 1));

    assign bus.data_in_ready  = bus.bias_valid && space && !rst;
    assign bus.bias_ready     = bus.data_in_valid && space && !rst;
    assign bus.data_out       = head_data;
    assign bus.data_out_valid = (count != 2'd0);
    assign bus.data_out_last  = head_last;

    // Two-entry skid buffer: head drives the outputs, tail catches a beat during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (push) begin
                beat_cnt <= new_last ? '0 : beat_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= new_data;
                        head_last <= new_last;
                    end else begin
                        tail_data <= new_data;
                        tail_last <= new_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Push with pop only happens with one entry held: replace the head.
                    head_data <= new_data;
                    head_last <= new_last;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_value_bias_add.sv
// tb/tb_encoder_value_bias_add.sv - scoreboard bench for encoder_value_bias_add
module tb_encoder_value_bias_add;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    encoder_value_bias_add_if #(
        .DATA_IN_PRECISION_0(16), .BIAS_PRECISION_0(16),
        .DATA_OUT_PRECISION_0(17), .PARALLELISM(1)
    ) bus ();

    encoder_value_bias_add dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [16:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic logic [16:0] model(logic [15:0] d, logic [15:0] b);
        int s;
        s = $signed(d) + $signed(b) * 32;
`ifdef ENCODER_VALUE_BIAS_ADD_SAT_EN
        if (s > 65535)  s = 65535;
        if (s < -65536) s = -65536;
`endif
        return s[16:0];
    endfunction

    task automatic send(input logic [15:0] d, input logic [15:0] b, input logic [16:0] e,
                        output int waits);
        exp_t x;
        bus.data_in[0]    = d;
        bus.bias[0]       = b;
        bus.data_in_valid = 1'b1;
        bus.bias_valid    = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.data_in_ready) begin
                x.data = e;
                x.last = (exp_cnt == 31);
                sb.push_back(x);
                exp_cnt = (exp_cnt + 1) % 32;
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 50) begin
                check("accept_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        bus.data_in_valid = 1'b0;
        bus.bias_valid    = 1'b0;
    endtask

    task automatic send_m(input logic [15:0] d, input logic [15:0] b);
        int w;
        send(d, b, model(d, b), w);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Monitor: pops expected beats on every output transfer and checks stall stability.
    initial begin
        logic        was_rst;
        logic        stalled;
        logic [16:0] prev_data;
        logic        prev_last;
        exp_t        x;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(posedge clk);
            was_rst = rst;
            @(negedge clk);
            if (was_rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(bus.data_out_valid), 32'd1);
                    check("hold_data", 32'(bus.data_out[0]), 32'(prev_data));
                    check("hold_last", 32'(bus.data_out_last), 32'(prev_last));
                end
                if (bus.data_out_valid && bus.data_out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", bus.data_out[0]);
                    end else begin
                        x = sb.pop_front();
                        check("beat_data", 32'(bus.data_out[0]), 32'(x.data));
                        check("beat_last", 32'(bus.data_out_last), 32'(x.last));
                    end
                end
                stalled   = bus.data_out_valid && !bus.data_out_ready;
                prev_data = bus.data_out[0];
                prev_last = bus.data_out_last;
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1;
        bus.data_in[0]     = '0;
        bus.bias[0]        = '0;
        bus.data_in_valid  = 1'b0;
        bus.bias_valid     = 1'b0;
        bus.data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.data_in_valid = 1'b1;
        bus.bias_valid    = 1'b1;
        @(negedge clk);
        check("rst_data_in_ready", 32'(bus.data_in_ready), 32'd0);
        check("rst_bias_ready", 32'(bus.bias_ready), 32'd0);
        check("rst_valid", 32'(bus.data_out_valid), 32'd0);
        check("rst_data", 32'(bus.data_out[0]), 32'd0);
        check("rst_last", 32'(bus.data_out_last), 32'd0);
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
        bus.bias_valid    = 1'b0;
        rst = 1'b0;

        // 1.0 + 1.0 with one cycle latency
        send(16'h0100, 16'h0008, 17'h00200, w);
        check("first_accept_wait", 32'(w), 32'd0);
        check("latency_valid", 32'(bus.data_out_valid), 32'd1);
        check("latency_data", 32'(bus.data_out[0]), 32'h00200);
`ifdef ENCODER_VALUE_BIAS_ADD_SAT_EN
        send(16'h7FFF, 16'h7FFF, 17'h0FFFF, w);
        send(16'h8000, 16'h8000, 17'h10000, w);
`else
        send(16'h7FFF, 16'h7FFF, 17'h07FDF, w);
        send(16'h8000, 16'h8000, 17'h18000, w);
`endif
        send(16'hFF00, 16'h0008, 17'h00000, w);
        send(16'h0180, 16'hFFFC, 17'h00100, w);
        // rest of the row plus the first beat of the next row, back to back
        for (int i = 5; i < 33; i++) begin
            send_m(16'(i * 37 - 300), 16'(i * 3 - 40));
        end
        drain();

        // output stall under continuous input
        bus.data_out_ready = 1'b0;
        send_m(16'h1234, 16'h0011);
        send_m(16'hF00D, 16'hFFF0);
        fork
            send_m(16'h0042, 16'h0002);
            begin
                repeat (3) @(negedge clk);
                check("stall_data_in_ready", 32'(bus.data_in_ready), 32'd0);
                check("stall_bias_ready", 32'(bus.bias_ready), 32'd0);
                check("stall_valid", 32'(bus.data_out_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.data_out_ready = 1'b1;
            end
        join
        drain();

        // bias missing: no transfer until it arrives
        bus.data_in[0]    = 16'h0200;
        bus.bias[0]       = 16'h0010;
        bus.data_in_valid = 1'b1;
        bus.bias_valid    = 1'b0;
        repeat (2) @(negedge clk);
        check("nobias_data_in_ready", 32'(bus.data_in_ready), 32'd0);
        check("nobias_bias_ready", 32'(bus.bias_ready), 32'd1);
        check("nobias_valid", 32'(bus.data_out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0200, 16'h0010, 17'h00400, w);
        check("bias_rise_wait", 32'(w), 32'd0);
        drain();

        // reset with two beats buffered and the counter at 17
        while (exp_cnt != 15) send_m(16'(exp_cnt * 11), 16'h0001);
        drain();
        bus.data_out_ready = 1'b0;
        send_m(16'h0AAA, 16'h0005);
        send_m(16'h0BBB, 16'h0006);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_valid", 32'(bus.data_out_valid), 32'd0);
        check("post_rst_data", 32'(bus.data_out[0]), 32'd0);
        bus.data_out_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            send_m(16'(i * 256 - 4000), 16'(100 - i * 9));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
